// File: rtl/i2c_txn_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package  : i2c_pkg
// Purpose  : i2c_ctrl command opcodes, sequencer states, step tables.
// Revision : 1.0
// ============================================================================
package i2c_pkg;

  localparam logic [2:0] c_OP_START     = 3'd0;
  localparam logic [2:0] c_OP_STOP      = 3'd1;
  localparam logic [2:0] c_OP_WRITE     = 3'd2;
  localparam logic [2:0] c_OP_READ_ACK  = 3'd3;
  localparam logic [2:0] c_OP_READ_NACK = 3'd4;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_CMD   = 3'd1;
  localparam logic [2:0] c_ST_WAIT  = 3'd2;
  localparam logic [2:0] c_ST_ABORT = 3'd3;
  localparam logic [2:0] c_ST_RESP  = 3'd4;

  localparam logic [2:0] c_WR_STEPS = 3'd5;
  localparam logic [2:0] c_RD_STEPS = 3'd7;

  function automatic logic [2:0] step_op(input logic rw, input logic [2:0] step);
    logic [2:0] op;
    op = c_OP_STOP;
    if (!rw) begin
      case (step)
        3'd0:                op = c_OP_START;
        3'd1, 3'd2, 3'd3:    op = c_OP_WRITE;
        default:             op = c_OP_STOP;
      endcase
    end else begin
      case (step)
        3'd0, 3'd3:          op = c_OP_START;
        3'd1, 3'd2, 3'd4:    op = c_OP_WRITE;
        3'd5:                op = c_OP_READ_NACK;
        default:             op = c_OP_STOP;
      endcase
    end
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_txn_seq_if.sv
`default_nettype none
// ============================================================================
// Interface : i2c_txn_seq_if
// Purpose   : host request/response and i2c_ctrl command/completion bundle.
// Revision  : 1.0
// ============================================================================
interface i2c_txn_seq_if;

  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_dev;
  logic [7:0] req_reg;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_err;
  logic [7:0] rsp_rdata;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_wdata;
  logic       eng_done;
  logic       eng_ack;
  logic [7:0] eng_rdata;
  logic       busy;

  // Sequencer side
  modport slave (
    input  req_valid, req_rw, req_dev, req_reg, req_wdata,
    input  cmd_ready, eng_done, eng_ack, eng_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output cmd_valid, cmd_op, cmd_wdata, busy
  );

  // Host register block and byte engine side
  modport master (
    output req_valid, req_rw, req_dev, req_reg, req_wdata,
    output cmd_ready, eng_done, eng_ack, eng_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  cmd_valid, cmd_op, cmd_wdata, busy
  );

endinterface
`default_nettype wire

// File: rtl/i2c_txn_seq.sv
`default_nettype none
// ============================================================================
// Module   : i2c_txn_seq
// Purpose  : single-byte register read/write sequencer above i2c_ctrl.
//            Define I2C_SEQ_RETRY_EN to retry on address-byte NACK.
// Revision : 1.0
// ============================================================================
module i2c_txn_seq
  import i2c_pkg::*;
#(
  parameter int unsigned RETRY_MAX = 3
) (
  input  wire logic    clk,
  input  wire logic    reset,
  i2c_txn_seq_if.slave bus
);

  localparam logic [2:0] c_WR_LAST = c_WR_STEPS - 3'd1;
  localparam logic [2:0] c_RD_LAST = c_RD_STEPS - 3'd1;

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [2:0] r_step;
  logic       r_rw;
  logic [6:0] r_dev;
  logic [7:0] r_reg;
  logic [7:0] r_wdata;
  logic [7:0] r_rdata;
  logic       r_abort;
  logic       r_err;

  logic [2:0] w_op;
  logic [7:0] w_byte;
  logic       w_accept;
  logic       w_done;
  logic       w_nack;
  logic       w_last;
  logic       w_restart;

  generate
    if (RETRY_MAX < 1 || RETRY_MAX > 7) begin : g_retry_max_range
      $error("i2c_txn_seq: RETRY_MAX must be in 1..7");
    end
  endgenerate

  // While aborting, the step index is frozen and the offered command is STOP.
  assign w_op     = r_abort ? c_OP_STOP : step_op(r_rw, r_step);
  assign w_accept = (r_state == c_ST_IDLE) && bus.req_valid;
  assign w_done   = (r_state == c_ST_WAIT) && bus.eng_done;
  assign w_nack   = w_done && (w_op == c_OP_WRITE) && !bus.eng_ack;
  assign w_last   = (r_step == (r_rw ? c_RD_LAST : c_WR_LAST));

  // Write-data byte only matters on WRITE steps; step 3 is WRITE only for writes.
  always_comb begin
    w_byte = 8'h00;
    if (w_op == c_OP_WRITE) begin
      case (r_step)
        3'd1:    w_byte = {r_dev, 1'b0};
        3'd2:    w_byte = r_reg;
        3'd3:    w_byte = r_wdata;
        3'd4:    w_byte = {r_dev, 1'b1};
        default: w_byte = 8'h00;
      endcase
    end
  end

`ifdef I2C_SEQ_RETRY_EN
  localparam int unsigned c_RETRY_W = $clog2(RETRY_MAX + 1);

  logic [c_RETRY_W-1:0] r_retry;
  logic                 r_retry_go;
  logic                 w_retry_ok;

  assign w_retry_ok = (r_step == 3'd1) && (r_retry < c_RETRY_W'(RETRY_MAX));
  assign w_restart  = r_retry_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_retry    <= '0;
      r_retry_go <= 1'b0;
    end else if (w_accept) begin
      r_retry    <= '0;
      r_retry_go <= 1'b0;
    end else if (w_nack) begin
      r_retry_go <= w_retry_ok;
      if (w_retry_ok) r_retry <= r_retry + 1'b1;
    end else if (w_done && r_abort) begin
      r_retry_go <= 1'b0;
    end
  end
`else
  assign w_restart = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (bus.req_valid) w_state_nxt = c_ST_CMD;
      c_ST_CMD:   if (bus.cmd_ready) w_state_nxt = c_ST_WAIT;
      c_ST_ABORT: if (bus.cmd_ready) w_state_nxt = c_ST_WAIT;
      c_ST_WAIT: begin
        if (bus.eng_done) begin
          if (r_abort)     w_state_nxt = w_restart ? c_ST_CMD : c_ST_RESP;
          else if (w_nack) w_state_nxt = c_ST_ABORT;
          else if (w_last) w_state_nxt = c_ST_RESP;
          else             w_state_nxt = c_ST_CMD;
        end
      end
      c_ST_RESP:  w_state_nxt = c_ST_IDLE;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = c_OP_START;
    bus.cmd_wdata = 8'h00;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    bus.busy      = 1'b1;
    case (r_state)
      c_ST_IDLE: begin
        bus.req_ready = !reset;
        bus.busy      = 1'b0;
      end
      c_ST_CMD, c_ST_ABORT: begin
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = w_op;
        bus.cmd_wdata = w_byte;
      end
      c_ST_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = r_err;
      end
      default: ;
    endcase
  end

  assign bus.rsp_rdata = r_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_step  <= 3'd0;
      r_rw    <= 1'b0;
      r_dev   <= 7'd0;
      r_reg   <= 8'h00;
      r_wdata <= 8'h00;
      r_abort <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 8'h00;
    end else begin
      if (w_accept) begin
        r_rw    <= bus.req_rw;
        r_dev   <= bus.req_dev;
        r_reg   <= bus.req_reg;
        r_wdata <= bus.req_wdata;
        r_step  <= 3'd0;
        r_abort <= 1'b0;
        r_err   <= 1'b0;
      end
      if (w_done) begin
        if (r_abort) begin
          r_abort <= 1'b0;
          if (w_restart) r_step <= 3'd0;
          else           r_err  <= 1'b1;
        end else if (w_nack) begin
          r_abort <= 1'b1;
        end else if (!w_last) begin
          r_step <= r_step + 3'd1;
        end
        if (w_op == c_OP_READ_NACK) r_rdata <= bus.eng_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_txn_seq
// Purpose  : scoreboard bench for i2c_txn_seq with a byte-engine model.
// Revision : 1.0
// ============================================================================
module tb_i2c_txn_seq;

  localparam int RETRY_MAX = 3;
  localparam logic [2:0] T_START = 3'd0;
  localparam logic [2:0] T_STOP  = 3'd1;
  localparam logic [2:0] T_WRITE = 3'd2;
  localparam logic [2:0] T_RNACK = 3'd4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  i2c_txn_seq_if bus();

  i2c_txn_seq #(.RETRY_MAX(RETRY_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [10:0] exp_cmd[$];
  logic [8:0]  exp_rsp[$];
  bit          ack_q[$];
  logic [7:0]  rd_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          stall_len = -1;
  bit          hang = 1'b0;
  int          e_st = 0;
  int          e_cnt = 0;
  logic [7:0]  m_rdata = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Reference model: walk the transaction's step list, consuming one ack bit per WRITE.
  task automatic issue(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                       input logic [7:0] wd, input logic [7:0] rd, input logic [15:0] acks);
    logic [10:0] steps[$];
    int n_ack, retries, n;
    bit err, got_rd, restart, finished;
    steps.delete();
    steps.push_back({T_START, 8'h00});
    steps.push_back({T_WRITE, dev, 1'b0});
    steps.push_back({T_WRITE, rg});
    if (!rw) begin
      steps.push_back({T_WRITE, wd});
    end else begin
      steps.push_back({T_START, 8'h00});
      steps.push_back({T_WRITE, dev, 1'b1});
      steps.push_back({T_RNACK, 8'h00});
    end
    steps.push_back({T_STOP, 8'h00});
    n_ack = 0; retries = 0; err = 1'b0; got_rd = 1'b0; finished = 1'b0;
    while (!finished) begin
      restart = 1'b0;
      for (int i = 0; i < steps.size(); i++) begin
        exp_cmd.push_back(steps[i]);
        if (steps[i][10:8] == T_RNACK) got_rd = 1'b1;
        if (steps[i][10:8] == T_WRITE) begin
          n_ack++;
          if (!acks[n_ack-1]) begin
            exp_cmd.push_back({T_STOP, 8'h00});
`ifdef I2C_SEQ_RETRY_EN
            if (i == 1 && retries < RETRY_MAX) begin
              retries++;
              restart = 1'b1;
            end else
`endif
            err = 1'b1;
            break;
          end
        end
      end
      if (!restart) finished = 1'b1;
    end
    exp_rsp.push_back({err, got_rd ? rd : m_rdata});
    if (got_rd) begin
      m_rdata = rd;
      rd_q.push_back(rd);
    end
    for (int i = 0; i < n_ack; i++) ack_q.push_back(acks[i]);

    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_dev   = dev;
    bus.req_reg   = rg;
    bus.req_wdata = wd;
    n = 0;
    while (!bus.req_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'($urandom);
    bus.req_dev   = 7'($urandom);
    bus.req_reg   = 8'($urandom);
    bus.req_wdata = 8'($urandom);
    chk("cmd_valid_after_req", bus.cmd_valid, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_cmd.size() != 0 || exp_rsp.size() != 0 || bus.busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_cmd", exp_cmd.size(), 0);
    chk("drain_rsp", exp_rsp.size(), 0);
  endtask

  // Byte engine model: optional ready stall, done after a short latency.
  initial begin : engine
    logic [2:0] e_op;
    e_op = 3'd0;
    bus.cmd_ready = 1'b0;
    bus.eng_done  = 1'b0;
    bus.eng_ack   = 1'b0;
    bus.eng_rdata = 8'h00;
    forever begin
      @(negedge clk);
      bus.eng_done  = 1'b0;
      bus.cmd_ready = 1'b0;
      if (reset) begin
        e_st = 0;
        e_cnt = 0;
      end else if (e_st == 0) begin
        if (bus.cmd_valid) begin
          if (e_cnt > 0) e_cnt--;
          else begin
            bus.cmd_ready = 1'b1;
            e_op = bus.cmd_op;
            e_st = 1;
            e_cnt = $urandom_range(0, 3);
          end
        end else if ($urandom_range(0, 7) == 0) begin
          bus.eng_done  = 1'b1;
          bus.eng_ack   = 1'b0;
          bus.eng_rdata = 8'($urandom);
        end
      end else if (!hang) begin
        if (e_cnt > 0) e_cnt--;
        else begin
          bus.eng_done  = 1'b1;
          bus.eng_ack   = 1'($urandom);
          bus.eng_rdata = 8'($urandom);
          if (e_op == T_WRITE) bus.eng_ack = (ack_q.size() != 0) ? ack_q.pop_front() : 1'b1;
          if (e_op == T_RNACK && rd_q.size() != 0) bus.eng_rdata = rd_q.pop_front();
          e_st = 0;
          e_cnt = (stall_len >= 0) ? stall_len : $urandom_range(0, 2);
        end
      end
    end
  end

  initial begin : monitor
    logic [10:0] ec;
    logic [8:0]  er;
    bit          prev_stall;
    logic [2:0]  prev_op;
    logic [7:0]  prev_wd;
    prev_stall = 1'b0;
    prev_op = 3'd0;
    prev_wd = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (bus.cmd_valid && prev_stall) begin
          chk("stall_op_stable", bus.cmd_op, prev_op);
          chk("stall_wdata_stable", bus.cmd_wdata, prev_wd);
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
          if (exp_cmd.size() == 0) begin
            n_total++;
            $display("FAIL cmd_extra: got op=%0d wdata=0x%02h, expected no command", bus.cmd_op, bus.cmd_wdata);
          end else begin
            ec = exp_cmd.pop_front();
            chk("cmd_op", bus.cmd_op, ec[10:8]);
            chk("cmd_wdata", bus.cmd_wdata, ec[7:0]);
          end
        end
        if (bus.rsp_valid) begin
          if (exp_rsp.size() == 0) begin
            n_total++;
            $display("FAIL rsp_extra: got rsp_err=%0d rdata=0x%02h, expected no response", bus.rsp_err, bus.rsp_rdata);
          end else begin
            er = exp_rsp.pop_front();
            chk("rsp_err", bus.rsp_err, er[8]);
            chk("rsp_rdata", bus.rsp_rdata, er[7:0]);
          end
          chk("req_ready_in_resp", bus.req_ready, 0);
        end
        prev_stall = bus.cmd_valid && !bus.cmd_ready;
        prev_op = bus.cmd_op;
        prev_wd = bus.cmd_wdata;
      end
    end
  end

  initial begin : host
    logic [15:0] acks;
    int n;
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_dev   = 7'd0;
    bus.req_reg   = 8'h00;
    bus.req_wdata = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_cmd_op", bus.cmd_op, 0);
    chk("rst_cmd_wdata", bus.cmd_wdata, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", bus.req_ready, 1);

    issue(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 16'hFFFF);
    issue(1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, 16'hFFFF);
    issue(1'b0, 7'h50, 8'h33, 8'h5A, 8'h00, 16'hFFFD);
    issue(1'b1, 7'h2A, 8'h01, 8'h00, 8'h77, 16'hFFFE);
    issue(1'b1, 7'h2A, 8'h02, 8'h00, 8'h88, 16'hFFEF);
`ifdef I2C_SEQ_RETRY_EN
    issue(1'b0, 7'h50, 8'h10, 8'h11, 8'h00, 16'hFFFC);
    issue(1'b0, 7'h50, 8'h10, 8'h12, 8'h00, 16'hFFF0);
`endif
    drain();

    stall_len = 10;
    issue(1'b0, 7'h21, 8'h44, 8'h99, 8'h00, 16'hFFFF);
    drain();
    stall_len = -1;

    for (int t = 0; t < 60; t++) begin
      for (int b = 0; b < 16; b++) acks[b] = ($urandom_range(0, 7) != 0);
      issue(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), acks);
    end
    drain();

    // Reset while the sequencer waits on an engine completion.
    hang = 1'b1;
    exp_cmd.push_back({T_START, 8'h00});
    bus.req_valid = 1'b1;
    bus.req_rw    = 1'b0;
    bus.req_dev   = 7'h11;
    bus.req_reg   = 8'h22;
    bus.req_wdata = 8'h33;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (e_st == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    @(negedge clk);
    chk("wait_busy", bus.busy, 1);
    chk("wait_cmd_valid", bus.cmd_valid, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_req_ready", bus.req_ready, 0);
    chk("mid_rst_cmd_valid", bus.cmd_valid, 0);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_cmd_op", bus.cmd_op, 0);
    chk("mid_rst_rsp_rdata", bus.rsp_rdata, 0);
    reset = 1'b0;
    hang = 1'b0;
    m_rdata = 8'h00;
    @(negedge clk);
    chk("post_rst_req_ready", bus.req_ready, 1);
    chk("post_rst_cmd_pending", exp_cmd.size(), 0);

    issue(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 16'hFFFF);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_txn_seq.md
# i2c_txn_seq

Register-transaction sequencer sitting above the I2C byte engine (`i2c_ctrl`). Accepts one single-byte register read or write per request and breaks it into the engine's byte-level commands: START, WRITE, READ_ACK, READ_NACK and STOP. It monitors slave ACKs and issues an aborting STOP on NACK. It returns one response per request to the host-side register block.

## Interface
Parameters:
- RETRY_MAX, 3: maximum address-NACK retries; used only when `I2C_SEQ_RETRY_EN` is defined; legal range 1..7.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_rw  in  1  0 = write, 1 = read.
- req_dev  in  7  7-bit slave address.
- req_reg  in  8  register address.
- req_wdata  in  8  write data; ignored for reads.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  transaction ended on NACK; qualified by rsp_valid.
- rsp_rdata  out  8  read byte; holds its value between reads.
- cmd_valid  out  1  command offered to the engine.
- cmd_ready  in  1  engine accepts the command.
- cmd_op  out  3  command opcode: START=0, STOP=1, WRITE=2, READ_ACK=3, READ_NACK=4.
- cmd_wdata  out  8  byte for WRITE; 0 otherwise.
- eng_done  in  1  one-cycle pulse when the accepted command completes.
- eng_ack  in  1  slave ACK after a WRITE (1 = ACK); qualified by eng_done.
- eng_rdata  in  8  received byte; qualified by eng_done on READ_*.
- busy  out  1  high in every state except IDLE.

## Operation
- Write step list: START, WRITE {dev,0}, WRITE reg, WRITE wdata, STOP.
- Read step list: START, WRITE {dev,0}, WRITE reg, START (repeated), WRITE {dev,1}, READ_NACK, STOP.
- Request capture:
  - Request fields are registered on handshake.
  - Request inputs are don't-care afterwards.
- A 3-bit step index selects cmd_op and cmd_wdata from the captured request.
- States:
  - IDLE: req_ready=1. On req_valid go to CMD with step=0.
  - CMD: cmd_valid=1. On cmd_ready go to WAIT.
  - WAIT: on eng_done, evaluate the completed step:
    - WRITE with eng_ack=0: go to ABORT.
    - Last step (STOP): go to RESP.
    - Otherwise: step+1, go to CMD.
  - ABORT: issue STOP (CMD/WAIT handshake reused). On its eng_done go to RESP with err=1.
  - RESP: rsp_valid=1 for one cycle, then go to IDLE.
- Command rules:
  - cmd_op and cmd_wdata are stable while cmd_valid=1 and cmd_ready=0.
  - cmd_valid never drops without a handshake, except on reset.
- eng_ack is ignored for START, STOP and READ_* commands.
- eng_done outside WAIT is ignored; it does not change state.
- rsp_rdata updates from eng_rdata only on eng_done of READ_NACK.
  - It is not cleared on error.
- A NACK during the abort STOP cannot occur (STOP has no ACK); no special handling.

## Timing
- Reset values: req_ready=0 during reset, then 1 in IDLE. All other outputs 0: rsp_valid, rsp_err, rsp_rdata=0, cmd_valid, cmd_op=0, cmd_wdata=0, busy.
- Request handshake at cycle N gives cmd_valid=1 at cycle N+1.
- Command handshake at cycle M gives cmd_valid=0 at cycle M+1.
- eng_done at cycle K gives the next cmd_valid=1 at K+1.
- STOP eng_done at cycle K gives rsp_valid=1 at K+1 and req_ready=1 at K+2.
- Earliest next request handshake is K+2. No back-to-back acceptance during RESP.
- eng_done coincident with cmd_ready in the same state is impossible by engine contract; the sequencer has no ordering assumption beyond WAIT.
- Reset mid-transaction:
  - State returns to IDLE on the next edge; cmd_valid drops.
  - No response is generated.
  - The engine shares the reset.

## Configuration
- Macro: `I2C_SEQ_RETRY_EN`.
- Defined:
  - A NACK on step 1 (first address byte) goes to ABORT. After the STOP completes, the sequencer restarts from step 0 with the same captured request.
  - Retries are counted in a $clog2(RETRY_MAX+1)-bit counter, cleared on request acceptance.
  - After RETRY_MAX retries, the next NACK ends with rsp_err=1.
  - NACK on any other step never retries.
- Undefined: any NACK goes directly to ABORT followed by an error response; no retry counter is present.

## Structure
- Shared package `i2c_pkg` holds:
  - cmd_op encoding localparams.
  - Sequencer state encoding.
  - Step-count constants (WR_STEPS=5, RD_STEPS=7).
  - Step-to-op lookup function.
- No sub-module: a single module with a 2-process FSM plus a step/retry datapath.

## Test plan
- Write dev=0x50 reg=0x10 data=0xA5, engine always ACKs -> command sequence START, WRITE 0xA0, WRITE 0x10, WRITE 0xA5, STOP; rsp_valid with rsp_err=0.
- Read dev=0x50 reg=0x22, eng_rdata=0x3C on READ_NACK -> START, WRITE 0xA0, WRITE 0x22, START, WRITE 0xA1, READ_NACK, STOP; rsp_rdata=0x3C, rsp_err=0.
- Write with NACK on the reg byte -> STOP issued next; rsp_err=1; rsp_rdata unchanged.
- With `I2C_SEQ_RETRY_EN` and RETRY_MAX=3, address NACK 2 times then ACK -> 3 START..WRITE 0xA0 attempts; final rsp_err=0. With 4 NACKs -> 4 attempts; rsp_err=1.
- cmd_ready held low 10 cycles -> cmd_op and cmd_wdata stable; no extra commands. Reset asserted in WAIT -> next cycle IDLE, all outputs at reset values, no rsp_valid.
